// File: rtl/bip_pkg.sv
// Shared definitions for the BIP run-control sequencer: opcode values,
// sequencer state encoding, report frame layout and a byte selector.
package bip_pkg;

   localparam int NB_FRAME     = 48;
   localparam int NB_IDX       = 3;
   localparam int REPORT_BYTES = 6;

   // Instruction opcodes shared with the CPU decoder
   localparam logic [4:0] HLT  = 5'b00000;
   localparam logic [4:0] STO  = 5'b00001;
   localparam logic [4:0] LD   = 5'b00010;
   localparam logic [4:0] LDI  = 5'b00011;
   localparam logic [4:0] ADD  = 5'b00100;
   localparam logic [4:0] ADDI = 5'b00101;
   localparam logic [4:0] SUB  = 5'b00110;
   localparam logic [4:0] SUBI = 5'b00111;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_SEND    = 3'd2,
      ST_WAIT_TX = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Transmission order of the report bytes (byte 0 goes out first)
   localparam logic [NB_IDX-1:0] IDX_ACC_HI = 3'd0;
   localparam logic [NB_IDX-1:0] IDX_ACC_LO = 3'd1;
   localparam logic [NB_IDX-1:0] IDX_PC_HI  = 3'd2;
   localparam logic [NB_IDX-1:0] IDX_PC_LO  = 3'd3;
   localparam logic [NB_IDX-1:0] IDX_CYC_HI = 3'd4;
   localparam logic [NB_IDX-1:0] IDX_CYC_LO = 3'd5;
   localparam logic [NB_IDX-1:0] IDX_LAST   = 3'(REPORT_BYTES - 1);

   // Frame is packed {ACC, PC16, CYC}, most significant byte first
   function automatic logic [7:0] report_byte(input logic [NB_FRAME-1:0] frame,
                                              input logic [NB_IDX-1:0]   idx);
      logic [7:0] b;
      case (idx)
         IDX_ACC_HI: b = frame[47:40];
         IDX_ACC_LO: b = frame[39:32];
         IDX_PC_HI:  b = frame[31:24];
         IDX_PC_LO:  b = frame[23:16];
         IDX_CYC_HI: b = frame[15:8];
         IDX_CYC_LO: b = frame[7:0];
         default:    b = 8'h00;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/bip_report_tx.sv
// Report streamer: holds the 48-bit halt snapshot, walks the byte index and
// runs the start/done handshake with the UART transmitter.
// Handshake: o_tx_start is a one-cycle pulse with o_tx_data stable; the byte
// is considered consumed on the first i_tx_done seen while i_wait is high.
module bip_report_tx
   import bip_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_load,
   input  logic [NB_FRAME-1:0] i_frame,
   input  logic                i_wait,
   input  logic                i_tx_done,
   output logic                o_tx_start,
   output logic [7:0]          o_tx_data,
   output logic                o_frame_done
);

   logic [NB_FRAME-1:0] frame_q, frame_d;
   logic [NB_IDX-1:0]   idx_q, idx_d;
   logic                tx_start_q, tx_start_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                byte_ack;
   logic                last_byte;

   assign byte_ack     = i_wait && i_tx_done;
   assign last_byte    = (idx_q == IDX_LAST);
   assign o_frame_done = byte_ack && last_byte;
   assign o_tx_start   = tx_start_q;
   assign o_tx_data    = tx_data_q;

   // Load byte 0 on snapshot, or the next byte on an acknowledged non-final byte
   always_comb begin
      frame_d    = frame_q;
      idx_d      = idx_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      if (i_load) begin
         frame_d    = i_frame;
         idx_d      = '0;
         tx_start_d = 1'b1;
         tx_data_d  = report_byte(i_frame, '0);
      end else if (byte_ack && !last_byte) begin
         idx_d      = idx_q + 3'd1;
         tx_start_d = 1'b1;
         tx_data_d  = report_byte(frame_q, idx_q + 3'd1);
      end
   end

   // Streamer registers; reset abandons any partial frame
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         frame_q    <= '0;
         idx_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         frame_q    <= frame_d;
         idx_q      <= idx_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

endmodule

// File: rtl/bip_run_ctrl.sv
// Run-control sequencer for the BIP CPU: starts execution, gates the core
// with o_cpu_en, counts executed cycles and streams a 6-byte halt report.
// Optional single-step support is compiled in with the macro BIP_STEP_EN.
module bip_run_ctrl
   import bip_pkg::*;
#(
   parameter int NB_OPCODE = 5,
   parameter int NB_DATA   = 16,
   parameter int NB_PC     = 11,
   parameter int NB_CYCLES = 16,
   parameter int NB_BYTE   = 8
)(
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [NB_OPCODE-1:0] i_opcode,
   input  logic [NB_PC-1:0]     i_pc,
   input  logic [NB_DATA-1:0]   i_acc,
   input  logic                 i_tx_done,
`ifdef BIP_STEP_EN
   input  logic                 i_step_mode,
   input  logic                 i_step,
`endif
   output logic                 o_cpu_en,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_tx_start,
   output logic [NB_BYTE-1:0]   o_tx_data,
   output logic [NB_CYCLES-1:0] o_cycles,
   output state_t               o_dbg_state
);

   state_t               state_q, state_d;
   logic [NB_CYCLES-1:0] cycles_q, cycles_d;
   logic                 is_hlt;
   logic                 snap_load;
   logic                 frame_done;
   logic                 accept_start;
   logic [NB_FRAME-1:0]  snapshot;

`ifdef BIP_STEP_EN
   logic step_mode_q, step_mode_d;
   logic step_snap_q, step_snap_d;
   logic step_halt_q, step_halt_d;
`endif

   assign is_hlt       = (i_opcode == NB_OPCODE'(HLT));
   assign accept_start = (state_q == ST_IDLE) && i_start;
   assign snapshot     = {i_acc, 16'(i_pc), cycles_q};
   assign o_cycles     = cycles_q;
   assign o_dbg_state  = state_q;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (i_start) state_d = ST_RUN;
         ST_RUN:     if (snap_load) state_d = ST_SEND;
         ST_SEND:    state_d = ST_WAIT_TX;
         ST_WAIT_TX: if (i_tx_done) state_d = frame_done ? ST_DONE : ST_SEND;
         ST_DONE: begin
`ifdef BIP_STEP_EN
            state_d = (step_mode_q && !step_halt_q) ? ST_RUN : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
         end
         default:    state_d = ST_IDLE;
      endcase
   end

   // Outputs and strobes; cpu enable is combinational so HLT never executes
   always_comb begin
      o_cpu_en  = 1'b0;
      snap_load = 1'b0;
      o_busy    = (state_q != ST_IDLE);
      o_done    = (state_q == ST_DONE);
      if (state_q == ST_RUN) begin
`ifdef BIP_STEP_EN
         if (step_mode_q) begin
            // Post-execution snapshot follows a stepped instruction by one cycle
            o_cpu_en  = i_step && !is_hlt && !step_snap_q;
            snap_load = step_snap_q || (i_step && is_hlt);
         end else begin
            o_cpu_en  = !is_hlt;
            snap_load = is_hlt;
         end
`else
         o_cpu_en  = !is_hlt;
         snap_load = is_hlt;
`endif
      end
   end

   // Cycle counter next value: cleared on start, saturating on executed cycles
   always_comb begin
      cycles_d = cycles_q;
      if (accept_start) begin
         cycles_d = '0;
      end else if (o_cpu_en && (cycles_q != '1)) begin
         cycles_d = cycles_q + NB_CYCLES'(1);
      end
   end

   // Cycle counter register
   always_ff @(posedge i_clk) begin
      if (i_reset) cycles_q <= '0;
      else         cycles_q <= cycles_d;
   end

`ifdef BIP_STEP_EN
   // Step bookkeeping: mode latched at start, pending snapshot, halt reached
   always_comb begin
      step_mode_d = step_mode_q;
      step_snap_d = step_snap_q;
      step_halt_d = step_halt_q;
      if (accept_start) begin
         step_mode_d = i_step_mode;
         step_snap_d = 1'b0;
         step_halt_d = 1'b0;
      end else if (snap_load) begin
         step_snap_d = 1'b0;
         step_halt_d = !step_snap_q;
      end else if (o_cpu_en && step_mode_q) begin
         step_snap_d = 1'b1;
      end
   end

   // Step bookkeeping registers
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         step_mode_q <= 1'b0;
         step_snap_q <= 1'b0;
         step_halt_q <= 1'b0;
      end else begin
         step_mode_q <= step_mode_d;
         step_snap_q <= step_snap_d;
         step_halt_q <= step_halt_d;
      end
   end
`endif

   bip_report_tx u_report_tx (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_load       (snap_load),
      .i_frame      (snapshot),
      .i_wait       (state_q == ST_WAIT_TX),
      .i_tx_done    (i_tx_done),
      .o_tx_start   (o_tx_start),
      .o_tx_data    (o_tx_data),
      .o_frame_done (frame_done)
   );

endmodule

// File: tb/tb_bip_run_ctrl.sv
// Directed bench for bip_run_ctrl: a tiny CPU model executes programs under
// o_cpu_en, a UART TX model answers each byte 10 cycles later, and report
// bytes are scored against hand-computed frames.
module tb_bip_run_ctrl;
   import bip_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_reset = 1'b1;
   logic        i_start = 1'b0;
   logic [4:0]  i_opcode;
   logic [10:0] i_pc;
   logic [15:0] i_acc;
   logic        i_tx_done;
   logic        o_cpu_en, o_busy, o_done, o_tx_start;
   logic [7:0]  o_tx_data;
   logic [15:0] o_cycles;
   state_t      o_dbg_state;
`ifdef BIP_STEP_EN
   logic        i_step_mode = 1'b0;
   logic        i_step = 1'b0;
`endif

   bip_run_ctrl dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_start     (i_start),
      .i_opcode    (i_opcode),
      .i_pc        (i_pc),
      .i_acc       (i_acc),
      .i_tx_done   (i_tx_done),
`ifdef BIP_STEP_EN
      .i_step_mode (i_step_mode),
      .i_step      (i_step),
`endif
      .o_cpu_en    (o_cpu_en),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_tx_start  (o_tx_start),
      .o_tx_data   (o_tx_data),
      .o_cycles    (o_cycles),
      .o_dbg_state (o_dbg_state)
   );

   // ---------------- CPU model ----------------
   logic        cpu_rst = 1'b1;
   logic [15:0] acc_init = 16'h0000;
   logic        force_hlt = 1'b0;
   logic [10:0] pc_m;
   logic [15:0] acc_m;
   logic [4:0]  prog_op [0:2047];
   logic [15:0] prog_k  [0:2047];

   assign i_opcode = force_hlt ? HLT : prog_op[pc_m];
   assign i_pc     = pc_m;
   assign i_acc    = acc_m;

   always @(posedge clk) begin
      if (cpu_rst) begin
         pc_m  <= '0;
         acc_m <= acc_init;
      end else if (o_cpu_en) begin
         case (i_opcode)
            LDI:     acc_m <= prog_k[pc_m];
            ADDI:    acc_m <= acc_m + prog_k[pc_m];
            SUBI:    acc_m <= acc_m - prog_k[pc_m];
            default: ;
         endcase
         pc_m <= pc_m + 11'd1;
      end
   end

   // ---------------- UART TX model / monitor ----------------
   logic       tx_done_m = 1'b0;
   logic       tx_done_spur = 1'b0;
   int         tx_cd = 0;
   int         en_cnt = 0;
   int         done_cnt = 0;
   logic [7:0] got_q[$];

   assign i_tx_done = tx_done_m | tx_done_spur;

   always @(negedge clk) begin
      #2;
      tx_done_m = 1'b0;
      if (i_reset) begin
         tx_cd = 0;
      end else begin
         if (tx_cd != 0) begin
            tx_cd = tx_cd - 1;
            if (tx_cd == 0) tx_done_m = 1'b1;
         end
         if (o_tx_start) begin
            got_q.push_back(o_tx_data);
            tx_cd = 10;
         end
      end
      if (o_cpu_en) en_cnt = en_cnt + 1;
      if (o_done)   done_cnt = done_cnt + 1;
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_vec = 0;
   int n_bad = 0;
   int b_got, b_en, b_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_frame(input logic [47:0] frame);
      for (int i = 0; i < 6; i++) exp_q.push_back(frame[47-8*i -: 8]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_prog();
      for (int i = 0; i < 2048; i++) begin
         prog_op[i] = ADDI;
         prog_k[i]  = 16'h0000;
      end
   endtask

   task automatic load_prog_basic();
      clear_prog();
      prog_op[0] = LDI;  prog_k[0] = 16'd5;
      prog_op[1] = ADDI; prog_k[1] = 16'd3;
      prog_op[2] = HLT;
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_reset = 1'b1;
      cpu_rst = 1'b1;
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      cpu_rst = 1'b0;
   endtask

   task automatic cpu_restart();
      @(negedge clk);
      cpu_rst = 1'b1;
      @(negedge clk);
      cpu_rst = 1'b0;
   endtask

   task automatic mark();
      b_got  = got_q.size();
      b_en   = en_cnt;
      b_done = done_cnt;
   endtask

   task automatic start_run();
      @(negedge clk);
      mark();
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
   endtask

   task automatic wait_frame(input string tag, input logic [15:0] cyc_exp,
                             input int en_exp, input int budget, input bit start_at_done);
      int  k;
      bit  seen;
      k = 0;
      seen = 1'b0;
      while (!seen && k < budget) begin
         @(negedge clk);
         k++;
         if (o_done) seen = 1'b1;
      end
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      if (start_at_done) i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk({tag, " byte_count"}, 32'(got_q.size() - b_got), 32'd6);
      for (int i = 0; i < 6; i++) begin
         logic [7:0] e;
         logic [7:0] g;
         e = exp_q.pop_front();
         g = (b_got + i < got_q.size()) ? got_q[b_got + i] : 8'hxx;
         chk($sformatf("%s byte%0d", tag, i), 32'(g), 32'(e));
      end
      chk({tag, " cycles"}, 32'(o_cycles), 32'(cyc_exp));
      chk({tag, " done_pulses"}, 32'(done_cnt - b_done), 32'd1);
      if (en_exp >= 0) chk({tag, " cpu_en_cycles"}, 32'(en_cnt - b_en), 32'(en_exp));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n_starts;
      int k;
      logic [10:0] pc_at_hlt;

      // Reset state
      load_prog_basic();
      acc_init = 16'h0000;
      do_reset();
      chk("rst state",    32'(o_dbg_state), 32'(ST_IDLE));
      chk("rst busy",     32'(o_busy),      32'd0);
      chk("rst cpu_en",   32'(o_cpu_en),    32'd0);
      chk("rst done",     32'(o_done),      32'd0);
      chk("rst tx_start", 32'(o_tx_start),  32'd0);
      chk("rst tx_data",  32'(o_tx_data),   32'd0);
      chk("rst cycles",   32'(o_cycles),    32'd0);

      // LDI 5; ADDI 3; HLT, with i_start offered on the DONE->IDLE edge
      start_run();
      chk("t1 state_run", 32'(o_dbg_state), 32'(ST_RUN));
      chk("t1 en_latency", 32'(o_cpu_en), 32'd1);
      push_frame(48'h0008_0002_0002);
      wait_frame("t1", 16'd2, 2, 2000, 1'b1);
      chk("t1 start_at_done state", 32'(o_dbg_state), 32'(ST_IDLE));
      chk("t1 start_at_done busy",  32'(o_busy), 32'd0);

      // HLT at PC 0
      clear_prog();
      prog_op[0] = HLT;
      acc_init = 16'h1234;
      cpu_restart();
      start_run();
      chk("t2 cpu_en_hlt", 32'(o_cpu_en), 32'd0);
      push_frame(48'h1234_0000_0000);
      wait_frame("t2", 16'd0, 0, 2000, 1'b0);

      // Saturating cycle counter
      clear_prog();
      acc_init = 16'h0000;
      cpu_restart();
      start_run();
      repeat (70000) @(negedge clk);
      chk("t3 cycles_sat", 32'(o_cycles), 32'h0000_FFFF);
      repeat (5) @(negedge clk);
      chk("t3 cycles_nowrap", 32'(o_cycles), 32'h0000_FFFF);
      pc_at_hlt = pc_m;
      force_hlt = 1'b1;
      push_frame({16'h0000, 5'b00000, pc_at_hlt, 16'hFFFF});
      wait_frame("t3", 16'hFFFF, -1, 2000, 1'b0);
      force_hlt = 1'b0;

      // Reset while waiting on byte 3
      load_prog_basic();
      acc_init = 16'h0000;
      cpu_restart();
      start_run();
      n_starts = 0;
      k = 0;
      while (n_starts < 4 && k < 2000) begin
         @(negedge clk);
         k++;
         if (o_tx_start) n_starts++;
      end
      chk("t4 reached_byte3", 32'(n_starts), 32'd4);
      @(negedge clk);
      chk("t4 in_wait_tx", 32'(o_dbg_state), 32'(ST_WAIT_TX));
      i_reset = 1'b1;
      @(negedge clk);
      i_reset = 1'b0;
      chk("t4 state",    32'(o_dbg_state), 32'(ST_IDLE));
      chk("t4 busy",     32'(o_busy),      32'd0);
      chk("t4 tx_start", 32'(o_tx_start),  32'd0);
      chk("t4 tx_data",  32'(o_tx_data),   32'd0);
      chk("t4 cycles",   32'(o_cycles),    32'd0);
      repeat (15) @(negedge clk);
      cpu_restart();
      start_run();
      push_frame(48'h0008_0002_0002);
      wait_frame("t4b", 16'd2, 2, 2000, 1'b0);

      // Spurious i_start in RUN and SEND, spurious i_tx_done in RUN
      load_prog_basic();
      cpu_restart();
      start_run();
      i_start = 1'b1;
      tx_done_spur = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      tx_done_spur = 1'b0;
      k = 0;
      while (!o_tx_start && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("t5 reached_send", 32'(o_tx_start), 32'd1);
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      push_frame(48'h0008_0002_0002);
      wait_frame("t5", 16'd2, 2, 2000, 1'b0);

`ifdef BIP_STEP_EN
      // Single-step: LDI 7; HLT
      clear_prog();
      prog_op[0] = LDI; prog_k[0] = 16'd7;
      prog_op[1] = HLT;
      acc_init = 16'h0000;
      cpu_restart();
      i_step_mode = 1'b1;
      start_run();
      i_step_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("s0 cpu_en_idle", 32'(o_cpu_en), 32'd0);
      chk("s0 state", 32'(o_dbg_state), 32'(ST_RUN));
      chk("s0 cycles", 32'(o_cycles), 32'd0);
      mark();
      push_frame(48'h0007_0001_0001);
      i_step = 1'b1;
      @(negedge clk);
      i_step = 1'b0;
      wait_frame("s1", 16'd1, 1, 2000, 1'b0);
      chk("s1 back_in_run", 32'(o_dbg_state), 32'(ST_RUN));
      repeat (3) @(negedge clk);
      mark();
      push_frame(48'h0007_0001_0001);
      i_step = 1'b1;
      @(negedge clk);
      i_step = 1'b0;
      wait_frame("s2", 16'd1, 0, 2000, 1'b0);
      chk("s2 idle", 32'(o_dbg_state), 32'(ST_IDLE));
`endif

      // Final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
